// File: rtl/conv_mac_pkg.sv
// Shared sizing helpers and the fixed-point rounding/saturation used by the MAC core.
package conv_mac_pkg;

    function automatic int acc_width(int din_p0, int w_p0, int roll_in, int icd);
        return din_p0 + w_p0 + $clog2(roll_in * icd) + 1;
    endfunction

    function automatic int acc_frac(int din_p1, int w_p1);
        return din_p1 + w_p1;
    endfunction

    // Floor toward -inf by arithmetic shift, then clamp to an out_p0-bit signed range.
    function automatic logic signed [63:0] round_sat(logic signed [63:0] acc, int shift, int out_p0);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = (shift >= 0) ? (acc >>> shift) : (acc <<< (-shift));
        hi = (64'sd1 <<< (out_p0 - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_p0 - 1));
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_core_if.sv
// Window, weight, bias and result streams of conv_mac_core, each with valid/ready.
interface conv_mac_core_if #(
    parameter int DATA_IN_0_PRECISION_0    = 16,
    parameter int WEIGHT_PRECISION_0       = 8,
    parameter int BIAS_PRECISION_0         = 8,
    parameter int DATA_OUT_0_PRECISION_0   = 8,
    parameter int ROLL_IN_NUM              = 8,
    parameter int ROLL_OUT_NUM             = 4,
    parameter int OUT_CHANNELS_PARALLELISM = 2
);
    logic [ROLL_IN_NUM-1:0][DATA_IN_0_PRECISION_0-1:0]                 data_in_0;
    logic                                                              data_in_0_valid;
    logic                                                              data_in_0_ready;
    logic [ROLL_OUT_NUM*OUT_CHANNELS_PARALLELISM-1:0][WEIGHT_PRECISION_0-1:0] weight;
    logic                                                              weight_valid;
    logic                                                              weight_ready;
    logic [OUT_CHANNELS_PARALLELISM-1:0][BIAS_PRECISION_0-1:0]         bias;
    logic                                                              bias_valid;
    logic                                                              bias_ready;
    logic [OUT_CHANNELS_PARALLELISM-1:0][DATA_OUT_0_PRECISION_0-1:0]   data_out_0;
    logic                                                              data_out_0_valid;
    logic                                                              data_out_0_ready;

    modport slave (
        input  data_in_0, data_in_0_valid, weight, weight_valid, bias, bias_valid, data_out_0_ready,
        output data_in_0_ready, weight_ready, bias_ready, data_out_0, data_out_0_valid
    );

    modport master (
        output data_in_0, data_in_0_valid, weight, weight_valid, bias, bias_valid, data_out_0_ready,
        input  data_in_0_ready, weight_ready, bias_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/chunk_roller.sv
// Holds one im2col window and hands it out as IN_NUM/OUT_NUM chunks, one per accepted beat.
module chunk_roller #(
    parameter int P0      = 16,
    parameter int IN_NUM  = 8,
    parameter int OUT_NUM = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_NUM-1:0][P0-1:0]    win_i,
    input  logic                         win_valid_i,
    output logic                         win_ready_o,
    output logic [OUT_NUM-1:0][P0-1:0]   chunk_o,
    output logic                         chunk_valid_o,
    input  logic                         chunk_ready_i
);
    localparam int NCH = IN_NUM / OUT_NUM;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IN_NUM-1:0][P0-1:0] win_q, win_d;
    logic [CW-1:0]             idx_q, idx_d;
    logic                      full_q, full_d;
    logic                      take, last_idx;

    assign take          = full_q && chunk_ready_i;
    assign last_idx      = (idx_q == CW'(NCH - 1));
    // A new window may land in the same cycle the last chunk leaves.
    assign win_ready_o   = rst && (!full_q || (take && last_idx));
    assign chunk_valid_o = full_q;
    assign chunk_o       = win_q[idx_q*OUT_NUM +: OUT_NUM];

    always_comb begin
        win_d  = win_q;
        idx_d  = idx_q;
        full_d = full_q;
        if (take) begin
            idx_d = last_idx ? '0 : idx_q + CW'(1);
            if (last_idx)
                full_d = 1'b0;
        end
        if (win_valid_i && win_ready_o) begin
            win_d  = win_i;
            idx_d  = '0;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end
endmodule

// File: rtl/conv_mac_core.sv
// Chunked MAC over all input-channel groups with replay for later output groups, bias, round/saturate.
module conv_mac_core #(
    parameter int DATA_IN_0_PRECISION_0    = 16,
    parameter int DATA_IN_0_PRECISION_1    = 3,
    parameter int WEIGHT_PRECISION_0       = 8,
    parameter int WEIGHT_PRECISION_1       = 4,
    parameter int BIAS_PRECISION_0         = 8,
    parameter int BIAS_PRECISION_1         = 4,
    parameter int DATA_OUT_0_PRECISION_0   = 8,
    parameter int DATA_OUT_0_PRECISION_1   = 4,
    parameter int ROLL_IN_NUM              = 8,
    parameter int ROLL_OUT_NUM             = 4,
    parameter int IN_CHANNELS_DEPTH        = 2,
    parameter int OUT_CHANNELS_PARALLELISM = 2,
    parameter int OUT_CHANNELS_DEPTH       = 2,
    parameter int HAS_BIAS                 = 1
) (
    input logic           clk,
    input logic           rst,
    conv_mac_core_if.slave io
);
    import conv_mac_pkg::*;

    localparam int DIN_P0   = DATA_IN_0_PRECISION_0;
    localparam int W_P0     = WEIGHT_PRECISION_0;
    localparam int B_P0     = BIAS_PRECISION_0;
    localparam int OUT_P0   = DATA_OUT_0_PRECISION_0;
    localparam int OCP      = OUT_CHANNELS_PARALLELISM;
    localparam int OCD      = OUT_CHANNELS_DEPTH;
    localparam int NCH      = ROLL_IN_NUM / ROLL_OUT_NUM;
    localparam int NACC     = IN_CHANNELS_DEPTH * NCH;
    localparam int ACC_W    = acc_width(DIN_P0, W_P0, ROLL_IN_NUM, IN_CHANNELS_DEPTH);
    localparam int ACC_FRAC = acc_frac(DATA_IN_0_PRECISION_1, WEIGHT_PRECISION_1);
    localparam int BIAS_SH  = ACC_FRAC - BIAS_PRECISION_1;
    localparam int OUT_SH   = ACC_FRAC - DATA_OUT_0_PRECISION_1;
    localparam int PW       = DIN_P0 + W_P0;
    localparam int CW       = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int GW       = (OCD > 1) ? $clog2(OCD) : 1;

    typedef logic [ROLL_OUT_NUM-1:0][DIN_P0-1:0] chunk_t;
    typedef logic signed [ACC_W-1:0]             acc_t;

    chunk_t                     roll_chunk, cur_chunk;
    logic                       roll_valid, roll_ready, roll_in_ready;
    chunk_t                     buf_q [NACC];
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [GW-1:0]              grp_q, grp_d;
    acc_t                       acc_q [OCP];
    acc_t                       acc_d [OCP];
    acc_t                       mac   [OCP];
    logic [OCP-1:0][OUT_P0-1:0] res, out_q, out_d;
    logic                       out_vld_q, out_vld_d;
    logic                       replay, last, out_free, fire;

    acc_t                       sum;
    logic signed [PW-1:0]       prod;
    logic signed [DIN_P0-1:0]   d_s;
    logic signed [W_P0-1:0]     w_s;
    logic signed [B_P0-1:0]     b_s;

    chunk_roller #(
        .P0      (DIN_P0),
        .IN_NUM  (ROLL_IN_NUM),
        .OUT_NUM (ROLL_OUT_NUM)
    ) u_roller (
        .clk           (clk),
        .rst           (rst),
        .win_i         (io.data_in_0),
        .win_valid_i   (io.data_in_0_valid && !replay),
        .win_ready_o   (roll_in_ready),
        .chunk_o       (roll_chunk),
        .chunk_valid_o (roll_valid),
        .chunk_ready_i (roll_ready)
    );

    // Groups after the first reuse the buffered chunks; the live window path is frozen meanwhile.
    assign replay    = (grp_q != '0);
    assign last      = (cnt_q == CW'(NACC - 1));
    assign cur_chunk = replay ? buf_q[cnt_q] : roll_chunk;
    assign out_free  = !out_vld_q || io.data_out_0_ready;
    assign fire      = rst && (replay || roll_valid) && io.weight_valid
                       && (HAS_BIAS == 0 || !last || io.bias_valid) && out_free;
    assign roll_ready = fire && !replay;

    assign io.weight_ready     = fire;
    assign io.bias_ready       = (HAS_BIAS != 0) && fire && last;
    assign io.data_in_0_ready  = roll_in_ready && !replay;
    assign io.data_out_0       = out_q;
    assign io.data_out_0_valid = out_vld_q;

    always_comb begin
        sum  = '0;
        prod = '0;
        d_s  = '0;
        w_s  = '0;
        b_s  = '0;
        for (int o = 0; o < OCP; o++) begin
            sum = (cnt_q == '0) ? '0 : acc_q[o];
            for (int i = 0; i < ROLL_OUT_NUM; i++) begin
                d_s  = cur_chunk[i];
                w_s  = io.weight[o*ROLL_OUT_NUM + i];
                prod = PW'(d_s) * PW'(w_s);
                sum  = sum + ACC_W'(prod);
            end
            b_s = io.bias[o];
            if (HAS_BIAS != 0 && last)
                sum = sum + (ACC_W'(b_s) <<< BIAS_SH);
            mac[o] = sum;
            res[o] = OUT_P0'(round_sat(64'(sum), OUT_SH, OUT_P0));
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        grp_d     = grp_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        acc_d     = acc_q;
        if (out_vld_q && io.data_out_0_ready)
            out_vld_d = 1'b0;
        if (fire) begin
            acc_d = mac;
            if (last) begin
                cnt_d     = '0;
                grp_d     = (grp_q == GW'(OCD - 1)) ? '0 : grp_q + GW'(1);
                out_vld_d = 1'b1;
                out_d     = res;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            grp_q     <= '0;
            acc_q     <= '{default: '0};
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Replay contents are always rewritten by group 0 before use, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fire && !replay)
            buf_q[cnt_q] <= roll_chunk;
    end
endmodule

// File: tb/tb_conv_mac_core.sv
// Randomized bench for conv_mac_core against an arithmetic per-beat reference model.
module tb_conv_mac_core;
    localparam int DP0 = 16, DP1 = 3, WP0 = 8, WP1 = 4, BP0 = 8, BP1 = 4, OP0 = 8, OP1 = 4;
    localparam int RIN = 8, ROUT = 4, ICD = 2, OCP = 2, OCD = 2, HB = 1;
    localparam int NCH = RIN / ROUT, NACC = ICD * NCH;
    localparam longint OSCALE = 8;   // 2^((DP1+WP1)-OP1)
    localparam longint BSCALE = 8;   // 2^((DP1+WP1)-BP1)

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_mac_core_if #(
        .DATA_IN_0_PRECISION_0(DP0), .WEIGHT_PRECISION_0(WP0), .BIAS_PRECISION_0(BP0),
        .DATA_OUT_0_PRECISION_0(OP0), .ROLL_IN_NUM(RIN), .ROLL_OUT_NUM(ROUT),
        .OUT_CHANNELS_PARALLELISM(OCP)
    ) bus ();

    conv_mac_core #(
        .DATA_IN_0_PRECISION_0(DP0), .DATA_IN_0_PRECISION_1(DP1),
        .WEIGHT_PRECISION_0(WP0), .WEIGHT_PRECISION_1(WP1),
        .BIAS_PRECISION_0(BP0), .BIAS_PRECISION_1(BP1),
        .DATA_OUT_0_PRECISION_0(OP0), .DATA_OUT_0_PRECISION_1(OP1),
        .ROLL_IN_NUM(RIN), .ROLL_OUT_NUM(ROUT), .IN_CHANNELS_DEPTH(ICD),
        .OUT_CHANNELS_PARALLELISM(OCP), .OUT_CHANNELS_DEPTH(OCD), .HAS_BIAS(HB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int checks = 0;
    int errors = 0;
    int wacc;
    bit done;

    int     dwin  [0:63][0:RIN-1];
    int     wbeat [0:511][0:ROUT*OCP-1];
    int     bbeat [0:127][0:OCP-1];
    longint expv  [0:127][0:OCP-1];

    task automatic chk(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(32'(hi - lo), 0));
    endfunction

    task automatic gen(int t, int npix);
        for (int n = 0; n < npix*ICD; n++)
            for (int i = 0; i < RIN; i++)
                case (t)
                    2, 3:    dwin[n][i] = 32767;
                    4:       dwin[n][i] = (n % ICD == 0 && i == 0) ? 1 : 0;
                    5:       dwin[n][i] = (n % ICD == 0 && i == 0) ? -1 : 0;
                    7, 8:    dwin[n][i] = rnd(-8, 8);
                    9:       dwin[n][i] = rnd(-32768, 32767);
                    default: dwin[n][i] = 1;
                endcase
        for (int j = 0; j < npix*OCD*NACC; j++)
            for (int e = 0; e < ROUT*OCP; e++)
                case (t)
                    2:       wbeat[j][e] = 127;
                    3:       wbeat[j][e] = -128;
                    4, 5:    wbeat[j][e] = 1;
                    6:       wbeat[j][e] = ((j / NACC) % OCD == 0) ? 16 : 32;
                    7, 8:    wbeat[j][e] = rnd(-16, 16);
                    9:       wbeat[j][e] = rnd(-128, 127);
                    default: wbeat[j][e] = 16;
                endcase
        for (int b = 0; b < npix*OCD; b++)
            for (int o = 0; o < OCP; o++)
                case (t)
                    1:       bbeat[b][o] = 16;
                    7, 8, 9: bbeat[b][o] = rnd(-128, 127);
                    default: bbeat[b][o] = 0;
                endcase
        // Beat b = pixel b/OCD, group b%OCD; weight beats run window-major then chunk.
        for (int b = 0; b < npix*OCD; b++)
            for (int o = 0; o < OCP; o++) begin
                longint acc, q;
                acc = 0;
                for (int w = 0; w < ICD; w++)
                    for (int k = 0; k < NCH; k++)
                        for (int i = 0; i < ROUT; i++)
                            acc += longint'(dwin[(b/OCD)*ICD + w][k*ROUT + i])
                                 * longint'(wbeat[b*NACC + w*NCH + k][o*ROUT + i]);
                if (HB != 0) acc += longint'(bbeat[b][o]) * BSCALE;
                q = acc / OSCALE;
                if (acc % OSCALE != 0 && acc < 0) q = q - 1;
                if (q > 127) q = 127;
                if (q < -128) q = -128;
                expv[b][o] = q;
            end
    endtask

    task automatic drv_data(int n, int gmax);
        for (int k = 0; k < n; k++) begin
            int tmo;
            repeat (rnd(0, gmax)) begin @(posedge clk); #1; end
            for (int i = 0; i < RIN; i++) bus.data_in_0[i] = DP0'(dwin[k][i]);
            bus.data_in_0_valid = 1'b1;
            tmo = 0;
            @(negedge clk);
            while (!bus.data_in_0_ready && tmo < 3000) begin @(negedge clk); tmo++; end
            if (tmo >= 3000) begin chk("tmo_din", tmo, 0); bus.data_in_0_valid = 1'b0; return; end
            @(posedge clk); #1;
            bus.data_in_0_valid = 1'b0;
        end
    endtask

    task automatic drv_wgt(int n, int gmax);
        for (int j = 0; j < n; j++) begin
            int tmo;
            repeat (rnd(0, gmax)) begin @(posedge clk); #1; end
            for (int e = 0; e < ROUT*OCP; e++) bus.weight[e] = WP0'(wbeat[j][e]);
            bus.weight_valid = 1'b1;
            tmo = 0;
            @(negedge clk);
            while (!bus.weight_ready && tmo < 3000) begin @(negedge clk); tmo++; end
            if (tmo >= 3000) begin chk("tmo_wgt", tmo, 0); bus.weight_valid = 1'b0; return; end
            @(posedge clk);
            wacc++;
            #1;
            bus.weight_valid = 1'b0;
        end
    endtask

    task automatic drv_bias(int n, int gmax);
        for (int b = 0; b < n; b++) begin
            int tmo;
            repeat (rnd(0, gmax)) begin @(posedge clk); #1; end
            for (int o = 0; o < OCP; o++) bus.bias[o] = BP0'(bbeat[b][o]);
            bus.bias_valid = 1'b1;
            tmo = 0;
            @(negedge clk);
            while (!bus.bias_ready && tmo < 3000) begin @(negedge clk); tmo++; end
            if (tmo >= 3000) begin chk("tmo_bias", tmo, 0); bus.bias_valid = 1'b0; return; end
            @(posedge clk); #1;
            bus.bias_valid = 1'b0;
        end
    endtask

    task automatic chk_out(int t, int nb);
        int b = 0, cyc = 0, hold = 0;
        bit seen = 0, pv = 0, pr = 0;
        logic [OCP-1:0][OP0-1:0] pd;
        pd = '0;
        bus.data_out_0_ready = (t != 7);
        while (b < nb && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (bus.data_out_0_valid) begin
                seen = 1;
                if (pv && !pr)
                    for (int o = 0; o < OCP; o++) chk("out_stable", bus.data_out_0[o], pd[o]);
                if (bus.data_out_0_ready) begin
                    for (int o = 0; o < OCP; o++) chk("out_val", $signed(bus.data_out_0[o]), expv[b][o]);
                    b++;
                end
            end
            if (t == 7 && seen && hold < 20) begin
                if (hold == 15) begin
                    chk("wrdy_hold", bus.weight_ready, 0);
                    chk("drdy_hold", bus.data_in_0_ready, 0);
                end
                hold++;
            end
            pv = bus.data_out_0_valid;
            pr = bus.data_out_0_ready;
            pd = bus.data_out_0;
            @(posedge clk); #1;
            if (t == 7 && seen && hold < 20)
                bus.data_out_0_ready = 1'b0;
            else
                bus.data_out_0_ready = (t >= 8) ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
        if (b < nb) chk("tmo_out", b, nb);
        done = 1;
    endtask

    // While a later output group is running, no new window may be taken.
    task automatic mon_replay();
        while (!done) begin
            @(negedge clk);
            if (!done && (wacc % (OCD*NACC)) >= NACC)
                chk("drdy_replay", bus.data_in_0_ready, 0);
        end
    endtask

    task automatic run_test(int t, int npix);
        int gmax;
        gmax = (t >= 8) ? 3 : 0;
        gen(t, npix);
        wacc = 0;
        done = 0;
        @(posedge clk); #1;
        fork
            drv_data(npix*ICD, gmax);
            drv_wgt(npix*OCD*NACC, gmax);
            drv_bias(npix*OCD, gmax);
            chk_out(t, npix*OCD);
            mon_replay();
        join
    endtask

    initial begin
        bus.data_in_0        = '0;
        bus.weight           = '0;
        bus.bias             = '0;
        bus.data_in_0_valid  = 1'b1;
        bus.weight_valid     = 1'b1;
        bus.bias_valid       = 1'b1;
        bus.data_out_0_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  bus.data_out_0_valid, 0);
        chk("rst_dout", bus.data_out_0, 0);
        chk("rst_drdy", bus.data_in_0_ready, 0);
        chk("rst_wrdy", bus.weight_ready, 0);
        chk("rst_brdy", bus.bias_ready, 0);
        bus.data_in_0_valid = 1'b0;
        bus.weight_valid    = 1'b0;
        bus.bias_valid      = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_test(0, 2);
        run_test(1, 2);
        run_test(2, 2);
        run_test(3, 2);
        run_test(4, 2);
        run_test(5, 2);
        run_test(6, 3);
        run_test(7, 4);
        run_test(8, 6);

        // Stall a pixel with group 0's result pending, then reset mid-accumulation.
        @(posedge clk); #1;
        bus.data_out_0_ready = 1'b0;
        for (int i = 0; i < RIN; i++) bus.data_in_0[i] = DP0'(1);
        for (int e = 0; e < ROUT*OCP; e++) bus.weight[e] = WP0'(16);
        bus.bias = '0;
        bus.data_in_0_valid = 1'b1;
        bus.weight_valid    = 1'b1;
        bus.bias_valid      = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vld", bus.data_out_0_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld",  bus.data_out_0_valid, 0);
        chk("mid_rst_dout", bus.data_out_0, 0);
        chk("mid_rst_drdy", bus.data_in_0_ready, 0);
        chk("mid_rst_wrdy", bus.weight_ready, 0);
        chk("mid_rst_brdy", bus.bias_ready, 0);
        bus.data_in_0_valid = 1'b0;
        bus.weight_valid    = 1'b0;
        bus.bias_valid      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_test(9, 4);
        run_test(8, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
